dac_write_arbiter: RTL and testbench
====================================

DAC_WRITE_ARBITER -- requirements
Module: dac_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 12, DAC sample width.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, maximum CLK_50M cycles to wait for dac_done.
REQ-003 CLK_50M  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has a write pending; req0_chan  input  1  target channel (0=A, 1=B); req0_data  input  DATA_W  sample.
REQ-006 req0_ready  output  1  requester 0 write accepted this cycle.
REQ-007 req1_valid, req1_chan, req1_data, req1_ready: same directions, widths and meanings for requester 1.
REQ-008 dac_start  output  1  one-cycle strobe that launches one SPI DAC frame.
REQ-009 dac_chan  output  1  channel for the launched frame; dac_data  output  DATA_W  value for the launched frame.
REQ-010 dac_done  input  1  one-cycle pulse from the DAC driver at frame completion.
REQ-011 grant_id  output  1  requester owning the current or last transaction; busy  output  1  high outside IDLE.
REQ-012 timeout_err  output  1  sticky flag: a frame exceeded TIMEOUT_CYCLES.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-014 IDLE: if no reqN_valid, remain in IDLE with all strobes low.
REQ-015 IDLE with one valid: grant it; assert its reqN_ready combinationally in the same cycle; latch chan/data into holding registers; go to ISSUE.
REQ-016 IDLE with both valid: grant the requester holding round-robin priority; the other's ready stays low.
REQ-017 ISSUE: assert dac_start for exactly one cycle; dac_chan/dac_data driven from holding registers; go to WAIT.
REQ-018 dac_chan/dac_data SHALL stay stable from ISSUE until the next acceptance.
REQ-019 WAIT: count cycles from 0; on dac_done go to IDLE.
REQ-020 WAIT: if the count reaches TIMEOUT_CYCLES-1 without dac_done, set timeout_err and go to IDLE.
REQ-021 dac_done outside WAIT SHALL be ignored.
REQ-022 dac_done and the timeout count on the same cycle: completion wins; timeout_err not set.
REQ-023 On leaving WAIT, by done or timeout, priority SHALL pass to the requester not just served.
REQ-024 Acceptance-to-dac_start latency: 1 cycle; back-to-back throughput: one frame per (frame time + 2) cycles, with one mandatory IDLE cycle between frames.
REQ-025 At most one reqN_ready SHALL be high per cycle, and only in IDLE.
REQ-026 busy = (state != IDLE); grant_id updates only on acceptance.

Reset
REQ-027 RST high on a clock edge: state IDLE, priority to requester 0, timeout counter 0, holding registers 0.
REQ-028 Outputs during and after reset: dac_start 0, reqN_ready 0, busy 0, grant_id 0, timeout_err 0, dac_chan 0, dac_data 0.
REQ-029 RST mid-transaction (ISSUE or WAIT) SHALL abort it without a further dac_start; a subsequent dac_done is ignored.
REQ-030 timeout_err SHALL clear only through RST.

Structure
REQ-031 Package dac_arb_pkg SHALL hold the state enumeration (IDLE, ISSUE, WAIT), CHAN_A=0 / CHAN_B=1 constants and the default DATA_W.
REQ-032 The grant/priority logic SHALL be a sub-module rr_arbiter2: 2-way round-robin with request, grant and advance ports.
REQ-033 The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES).

Verification
REQ-034 req0 only, chan=0, data=12'hABC -> req0_ready in the accepting cycle; dac_start next cycle with dac_chan=0, dac_data=12'hABC; dac_done after 130 cycles -> busy low.
REQ-035 Both valid continuously after reset, data 12'h111 / 12'h222 -> grants alternate 0,1,0,1 over 4 frames; never both ready in one cycle.
REQ-036 dac_done never arrives -> after 4096 WAIT cycles timeout_err=1, FSM in IDLE, priority passed to the other requester; timeout_err stays 1 until RST.
REQ-037 RST asserted 10 cycles into WAIT, then dac_done pulsed -> all outputs at reset values; no dac_start; the dac_done is ignored.
REQ-038 dac_done on the same cycle as the timeout count -> timeout_err stays 0; normal completion.
REQ-039 Spurious dac_done while IDLE with no requests -> no state change; busy stays 0.

Source files
------------

// File: rtl/dac_arb_pkg.sv
// Shared types and constants for the two-requester SPI DAC write arbiter.
package dac_arb_pkg;

    // Default DAC sample width in bits.
    localparam int DAC_DATA_W_DEFAULT = 12;

    // DAC channel encodings.
    localparam logic CHAN_A = 1'b0;
    localparam logic CHAN_B = 1'b1;

    // Requester identifiers, also used as the round-robin priority value.
    localparam logic REQ_0 = 1'b0;
    localparam logic REQ_1 = 1'b1;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    // Identifier of the requester that did not just get served.
    function automatic logic other_req(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered priority.
// Priority only moves when the owner of a finished transaction is reported
// through advance_i/served_i, so a pending request cannot be starved.
module rr_arbiter2
    import dac_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    input  logic       served_i,
    output logic [1:0] gnt_o
);

    logic prio_q;
    logic prio_d;

    // Pick one winner; on a tie the requester holding priority wins.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (prio_q == REQ_1) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    // Hand priority to the requester that was not just served.
    always_comb begin
        prio_d = prio_q;
        if (advance_i) begin
            prio_d = other_req(served_i);
        end else begin
            prio_d = prio_q;
        end
    end

    // Priority register, requester 0 favoured out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= REQ_0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/dac_write_arbiter.sv
// DAC write arbiter: accepts one write from two requesters, launches one
// SPI DAC frame per write and waits for the driver's completion pulse,
// with a bounded wait that raises a sticky timeout flag.
// Frame sequence: IDLE (accept) -> ISSUE (dac_start) -> WAIT (done/timeout).
module dac_write_arbiter
    import dac_arb_pkg::*;
#(
    parameter int DATA_W         = DAC_DATA_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              CLK_50M,
    input  logic              RST,
    input  logic              req0_valid,
    input  logic              req0_chan,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_chan,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              dac_start,
    output logic              dac_chan,
    output logic [DATA_W-1:0] dac_data,
    input  logic              dac_done,
    output logic              grant_id,
    output logic              busy,
    output logic              timeout_err
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              hold_chan_q;
    logic [DATA_W-1:0] hold_data_q;
    logic              grant_q;
    logic              start_q;
    logic              busy_q;
    logic              terr_q;

    logic [1:0]        arb_req_s;
    logic [1:0]        arb_gnt_s;
    logic              accept_s;
    logic              accept_id_s;
    logic              acc_chan_s;
    logic [DATA_W-1:0] acc_data_s;
    logic              wait_exit_s;

    // Requests are only offered while idle; reset masks them so no
    // ready can be seen while RST is held.
    always_comb begin
        arb_req_s = 2'b00;
        if ((state_q == IDLE) && !RST) begin
            arb_req_s = {req1_valid, req0_valid};
        end else begin
            arb_req_s = 2'b00;
        end
    end

    rr_arbiter2 u_rr_arbiter2 (
        .clk_i     (CLK_50M),
        .rst_i     (RST),
        .req_i     (arb_req_s),
        .advance_i (wait_exit_s),
        .served_i  (grant_q),
        .gnt_o     (arb_gnt_s)
    );

    // Decode the winning requester and select its payload.
    always_comb begin
        accept_s    = arb_gnt_s[0] | arb_gnt_s[1];
        accept_id_s = arb_gnt_s[1];
        if (arb_gnt_s[1]) begin
            acc_chan_s = req1_chan;
            acc_data_s = req1_data;
        end else begin
            acc_chan_s = req0_chan;
            acc_data_s = req0_data;
        end
    end

    // A wait ends on completion or once the cycle budget is used up;
    // this is also the moment priority passes on.
    always_comb begin
        wait_exit_s = 1'b0;
        if (state_q == WAIT) begin
            wait_exit_s = dac_done || (cnt_q == CNT_LAST);
        end else begin
            wait_exit_s = 1'b0;
        end
    end

    // Transaction sequencer with registered strobes and status.
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            hold_chan_q <= CHAN_A;
            hold_data_q <= {DATA_W{1'b0}};
            grant_q     <= REQ_0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= CNT_ZERO;
                    if (accept_s) begin
                        hold_chan_q <= acc_chan_s;
                        hold_data_q <= acc_data_s;
                        grant_q     <= accept_id_s;
                        start_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ISSUE;
                    end else begin
                        start_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    start_q <= 1'b0;
                    busy_q  <= 1'b1;
                    cnt_q   <= CNT_ZERO;
                    state_q <= WAIT;
                end
                WAIT: begin
                    start_q <= 1'b0;
                    if (dac_done) begin
                        // Completion beats a coincident timeout.
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        terr_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                default: begin
                    start_q <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= CNT_ZERO;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready  = arb_gnt_s[0];
    assign req1_ready  = arb_gnt_s[1];
    assign dac_start   = start_q;
    assign dac_chan    = hold_chan_q;
    assign dac_data    = hold_data_q;
    assign grant_id    = grant_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_dac_write_arbiter.sv
// Testbench for dac_write_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model (cycle arithmetic per write).
module tb_dac_write_arbiter;

    localparam int DW = 12;
    localparam int TO = 4096;

    logic          CLK_50M = 1'b0;
    logic          RST = 1'b1;
    logic          req0_valid = 1'b0;
    logic          req0_chan = 1'b0;
    logic [DW-1:0] req0_data = 12'h000;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic          req1_chan = 1'b0;
    logic [DW-1:0] req1_data = 12'h000;
    logic          req1_ready;
    logic          dac_start;
    logic          dac_chan;
    logic [DW-1:0] dac_data;
    logic          dac_done = 1'b0;
    logic          grant_id;
    logic          busy;
    logic          timeout_err;

    int errors = 0;
    int checks = 0;

    always #10 CLK_50M = ~CLK_50M;

    dac_write_arbiter #(.DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .CLK_50M(CLK_50M), .RST(RST),
        .req0_valid(req0_valid), .req0_chan(req0_chan), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_chan(req1_chan), .req1_data(req1_data), .req1_ready(req1_ready),
        .dac_start(dac_start), .dac_chan(dac_chan), .dac_data(dac_data), .dac_done(dac_done),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    task automatic next_cycle();
        @(posedge CLK_50M);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; dac_done = 1'b0;
        next_cycle();
        next_cycle();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; req0_chan = 1'b1; req1_chan = 1'b1;
        req0_data = 12'hFFF; req1_data = 12'hFFF; dac_done = 1'b1;
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                RST = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; dac_done = 1'b0;
            end
            @(negedge CLK_50M);
            checks++;
            if ({req0_ready, req1_ready, dac_start, busy, grant_id, timeout_err, dac_chan} !== 7'b0000000
                || dac_data !== 12'h000) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got rdy=%b%b start=%b busy=%b gid=%b terr=%b chan=%b data=%h, expected all zero",
                         i, req0_ready, req1_ready, dac_start, busy, grant_id, timeout_err, dac_chan, dac_data);
            end
            next_cycle();
        end
    endtask

    task automatic test_single();
        int bad;
        do_reset();
        req0_valid = 1'b1; req0_chan = 1'b0; req0_data = 12'hABC;
        @(negedge CLK_50M);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || dac_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: got rdy0=%b rdy1=%b start=%b busy=%b, expected 1 0 0 0",
                     req0_ready, req1_ready, dac_start, busy);
        end
        next_cycle();
        req0_valid = 1'b0; req0_data = 12'h000;
        @(negedge CLK_50M);
        checks++;
        if (dac_start !== 1'b1 || dac_chan !== 1'b0 || dac_data !== 12'hABC || busy !== 1'b1
            || grant_id !== 1'b0 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_issue: got start=%b chan=%b data=%h busy=%b gid=%b rdy0=%b, expected 1 0 abc 1 0 0",
                     dac_start, dac_chan, dac_data, busy, grant_id, req0_ready);
        end
        bad = 0;
        for (int i = 1; i < 130; i++) begin
            next_cycle();
            @(negedge CLK_50M);
            if (dac_start !== 1'b0 || busy !== 1'b1 || dac_data !== 12'hABC) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL single_wait: got %0d bad cycles, expected 0", bad);
        end
        next_cycle();
        dac_done = 1'b1;
        next_cycle();
        dac_done = 1'b0;
        @(negedge CLK_50M);
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b0 || dac_data !== 12'hABC || dac_chan !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got busy=%b terr=%b data=%h chan=%b, expected 0 0 abc 0",
                     busy, timeout_err, dac_data, dac_chan);
        end
        next_cycle();
        req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 12'h001; req1_data = 12'h002;
        @(negedge CLK_50M);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_prio: got rdy0=%b rdy1=%b, expected 0 1", req0_ready, req1_ready);
        end
    endtask

    task automatic test_alternate();
        logic exp_id;
        int   bad;
        do_reset();
        req0_valid = 1'b1; req0_chan = 1'b0; req0_data = 12'h111;
        req1_valid = 1'b1; req1_chan = 1'b1; req1_data = 12'h222;
        exp_id = 1'b0;
        bad = 0;
        for (int f = 0; f < 4; f++) begin
            @(negedge CLK_50M);
            checks++;
            if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL alt_grant[%0d]: got rdy1/rdy0=%b%b, expected %b",
                         f, req1_ready, req0_ready, (exp_id ? 2'b10 : 2'b01));
            end
            next_cycle();
            @(negedge CLK_50M);
            checks++;
            if (dac_start !== 1'b1 || grant_id !== exp_id || dac_chan !== exp_id
                || dac_data !== (exp_id ? 12'h222 : 12'h111)) begin
                errors++;
                $display("FAIL alt_issue[%0d]: got start=%b gid=%b chan=%b data=%h, expected 1 %b %b %h",
                         f, dac_start, grant_id, dac_chan, dac_data, exp_id, exp_id,
                         (exp_id ? 12'h222 : 12'h111));
            end
            for (int k = 0; k < 3; k++) begin
                next_cycle();
                @(negedge CLK_50M);
                if (req0_ready || req1_ready || dac_start || !busy) bad++;
            end
            next_cycle();
            dac_done = 1'b1;
            @(negedge CLK_50M);
            if (req0_ready || req1_ready || dac_start || !busy) bad++;
            next_cycle();
            dac_done = 1'b0;
            exp_id = ~exp_id;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL alt_quiet: got %0d cycles with ready/start outside IDLE, expected 0", bad);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_spurious();
        do_reset();
        dac_done = 1'b1;
        @(negedge CLK_50M);
        checks++;
        if (busy !== 1'b0 || dac_start !== 1'b0) begin
            errors++;
            $display("FAIL spurious_pulse: got busy=%b start=%b, expected 0 0", busy, dac_start);
        end
        next_cycle();
        dac_done = 1'b0;
        @(negedge CLK_50M);
        checks++;
        if (busy !== 1'b0 || dac_start !== 1'b0 || grant_id !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL spurious_after: got busy=%b start=%b gid=%b terr=%b, expected 0 0 0 0",
                     busy, dac_start, grant_id, timeout_err);
        end
        next_cycle();
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge CLK_50M);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL spurious_prio: got rdy0=%b rdy1=%b, expected 1 0", req0_ready, req1_ready);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        do_reset();
        req0_valid = 1'b1; req0_chan = 1'b1; req0_data = 12'h7E7;
        next_cycle();
        req0_valid = 1'b0;
        @(negedge CLK_50M);
        checks++;
        if (dac_start !== 1'b1 || dac_data !== 12'h7E7) begin
            errors++;
            $display("FAIL midreset_issue: got start=%b data=%h, expected 1 7e7", dac_start, dac_data);
        end
        repeat (11) next_cycle();
        RST = 1'b1;
        next_cycle();
        RST = 1'b0;
        dac_done = 1'b1;
        @(negedge CLK_50M);
        checks++;
        if ({dac_start, busy, grant_id, timeout_err, dac_chan} !== 5'b00000 || dac_data !== 12'h000) begin
            errors++;
            $display("FAIL midreset_outputs: got start=%b busy=%b gid=%b terr=%b chan=%b data=%h, expected all zero",
                     dac_start, busy, grant_id, timeout_err, dac_chan, dac_data);
        end
        next_cycle();
        dac_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK_50M);
            if (dac_start || busy || timeout_err || req0_ready || req1_ready) bad++;
            next_cycle();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midreset_quiet: got %0d active cycles, expected 0", bad);
        end
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        req0_valid = 1'b1; req0_chan = 1'b1; req0_data = 12'h5A5;
        @(negedge CLK_50M);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_accept: got rdy0=%b, expected 1", req0_ready);
        end
        next_cycle();
        req0_valid = 1'b0;
        bad = 0;
        for (int i = 1; i <= TO; i++) begin
            next_cycle();
            @(negedge CLK_50M);
            if (busy !== 1'b1 || timeout_err !== 1'b0 || dac_start !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_window: got %0d early-exit cycles, expected 0", bad);
        end
        next_cycle();
        @(negedge CLK_50M);
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag: got busy=%b terr=%b, expected 0 1", busy, timeout_err);
        end
        next_cycle();
        req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 12'h0AA; req1_data = 12'h0BB; req1_chan = 1'b0;
        @(negedge CLK_50M);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_prio: got rdy0=%b rdy1=%b, expected 0 1", req0_ready, req1_ready);
        end
        next_cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge CLK_50M);
        checks++;
        if (dac_start !== 1'b1 || dac_data !== 12'h0BB || grant_id !== 1'b1) begin
            errors++;
            $display("FAIL timeout_next: got start=%b data=%h gid=%b, expected 1 0bb 1", dac_start, dac_data, grant_id);
        end
        repeat (2) next_cycle();
        dac_done = 1'b1;
        next_cycle();
        dac_done = 1'b0;
        @(negedge CLK_50M);
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got busy=%b terr=%b, expected 0 1", busy, timeout_err);
        end
        do_reset();
        @(negedge CLK_50M);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got terr=%b, expected 0", timeout_err);
        end
    endtask

    task automatic test_done_at_limit();
        do_reset();
        req1_valid = 1'b1; req1_chan = 1'b0; req1_data = 12'h3C3;
        next_cycle();
        req1_valid = 1'b0;
        repeat (TO) next_cycle();
        dac_done = 1'b1;
        @(negedge CLK_50M);
        checks++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL limit_last_wait: got busy=%b terr=%b, expected 1 0", busy, timeout_err);
        end
        next_cycle();
        dac_done = 1'b0;
        @(negedge CLK_50M);
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL limit_done_wins: got busy=%b terr=%b, expected 0 0", busy, timeout_err);
        end
    endtask

    // Randomized traffic. The model tracks, per accepted write, the cycle it
    // was accepted, the cycle the bench returns dac_done, and derives from
    // those the cycles in which start/busy/ready must be seen.
    task automatic test_random(input int ncyc);
        logic          v0, v1, c0, c1, prio, exp_r0, exp_r1, exp_start, exp_busy, in_wait;
        logic          exp_chan, exp_gid, lat_chan, lat_id;
        logic [DW-1:0] d0, d1, exp_data, lat_data;
        int            start_cyc, done_cyc, free_at;
        do_reset();
        v0 = 1'b0; v1 = 1'b0; c0 = 1'b0; c1 = 1'b0; d0 = 12'h000; d1 = 12'h000; prio = 1'b0;
        exp_chan = 1'b0; exp_gid = 1'b0; exp_data = 12'h000;
        lat_chan = 1'b0; lat_id = 1'b0; lat_data = 12'h000;
        start_cyc = -1; done_cyc = -1; free_at = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (!v0 && ($urandom_range(0, 3) == 0)) begin
                v0 = 1'b1; c0 = 1'($urandom_range(0, 1)); d0 = DW'($urandom);
            end
            if (!v1 && ($urandom_range(0, 3) == 0)) begin
                v1 = 1'b1; c1 = 1'($urandom_range(0, 1)); d1 = DW'($urandom);
            end
            in_wait = (c > start_cyc) && (c <= done_cyc);
            req0_valid = v0; req0_chan = c0; req0_data = d0;
            req1_valid = v1; req1_chan = c1; req1_data = d1;
            if (c == done_cyc) dac_done = 1'b1;
            else if (!in_wait && ($urandom_range(0, 15) == 0)) dac_done = 1'b1;
            else dac_done = 1'b0;
            exp_r0    = (c >= free_at) && v0 && (!v1 || (prio == 1'b0));
            exp_r1    = (c >= free_at) && v1 && (!v0 || (prio == 1'b1));
            exp_start = (c == start_cyc);
            exp_busy  = (c >= start_cyc) && (c <= done_cyc);
            if (exp_start) begin
                exp_chan = lat_chan; exp_data = lat_data; exp_gid = lat_id;
            end
            @(negedge CLK_50M);
            checks++;
            if ({req1_ready, req0_ready, dac_start, busy, grant_id, dac_chan, timeout_err}
                    !== {exp_r1, exp_r0, exp_start, exp_busy, exp_gid, exp_chan, 1'b0}
                || dac_data !== exp_data) begin
                errors++;
                $display("FAIL random[%0d]: got rdy1/0=%b%b start=%b busy=%b gid=%b chan=%b terr=%b data=%h, expected %b%b %b %b %b %b 0 %h",
                         c, req1_ready, req0_ready, dac_start, busy, grant_id, dac_chan, timeout_err, dac_data,
                         exp_r1, exp_r0, exp_start, exp_busy, exp_gid, exp_chan, exp_data);
            end
            if (exp_r0 || exp_r1) begin
                lat_id   = exp_r1;
                lat_chan = exp_r1 ? c1 : c0;
                lat_data = exp_r1 ? d1 : d0;
                if (exp_r1) v1 = 1'b0;
                else v0 = 1'b0;
                start_cyc = c + 1;
                done_cyc  = start_cyc + int'($urandom_range(1, 12));
                free_at   = done_cyc + 1;
                prio      = ~lat_id;
            end
            next_cycle();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; dac_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_spurious();
        test_reset_mid();
        test_timeout();
        test_done_at_limit();
        test_random(2000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
